mdio_mgmt_ctrl: RTL and testbench
=================================

// Module: mdio_mgmt_ctrl
// PURPOSE
//  MGMT-bus slave that drives an IEEE 802.3 Clause-22 MDIO master toward the RGMII PHY.
//  Software writes PHY/register address, opcode and write data, then polls busy/read data.
//  Sits beside the PIC, sysreg and debug slaves; its ack/rxe/rxd feed the system MGMT hub.
// PARAMETERS
//  BASE_ADDR    32'h0000_0300  MGMT window base; hit when mgmt_adr[31:4]==BASE_ADDR[31:4]
//  DIV_DEFAULT  8'd24          reset value of DIV; MDC period = 2*(DIV+1) clk (50MHz -> 1MHz)
// PORTS
//  clk       in   1   system clock; the only clock
//  rst       in   1   reset, synchronous, active-low
//  mgmt_req  in   1   one-cycle request strobe; adr/rwn/wen/txd valid with it
//  mgmt_adr  in   32  byte address
//  mgmt_rwn  in   1   1=read, 0=write
//  mgmt_wen  in   2   write lane enables: [0]=txd[15:0], [1]=txd[31:16]
//  mgmt_txd  in   32  write data
//  mgmt_ack  out  1   one-cycle ack, cycle after a hitting req; 0 otherwise
//  mgmt_rxe  out  1   read-data valid, same cycle as ack, reads only
//  mgmt_rxd  out  32  read data; 0 whenever rxe=0
//  mdio_clk  out  1   MDC
//  mdio_txe  out  1   MDIO output enable (pad tri-state control)
//  mdio_txd  out  1   MDIO driven value
//  mdio_rxd  in   1   MDIO pad input
// BEHAVIOUR
//  Reset (rst=0 at clk edge): ack=rxe=0, rxd=0, mdio_clk=0, txe=0, txd=1, busy=0, done=0,
//   DIV=DIV_DEFAULT, CMD=0, RDATA=0; any transfer in flight is aborted immediately.
//  Bus: requests outside the window are ignored (no ack). Latency exactly 1 cycle.
//   Write to read-only or unmapped offset: acked, no effect. Unmapped read: acked, rxd=0.
//  Register map (offset = adr[3:0]):
//   0x0 CMD  RW  [4:0] REGAD, [9:5] PHYAD, [10] OP (1=read, 0=write), [31:16] WDATA.
//        A write with wen[0]=1 while idle latches [10:0] and starts a frame; wen[1] latches WDATA.
//        A CMD write while busy is acked and fully ignored.
//   0x4 STAT RO  [0] busy, [1] done (sticky; cleared by a STAT read, or by a new start),
//        [31:16] RDATA (last read result). Same-cycle done-set wins over read-clear.
//   0x8 DIV  RW  [7:0]; lane 0 only; applies from the next bit period; DIV=0 gives 2-clk MDC.
//  Frame (64 bits, MSB first): 32x'1' preamble, ST=01, OP (read 10, write 01), PHYAD[4:0],
//   REGAD[4:0], TA, DATA[15:0]. Write: TA=10, DATA=WDATA, txe=1 for all 64 bits.
//   Read: txe=1 for bits 0..45, txe=0 for bits 46..63 (TA + data).
//  Bit timing: each bit = low phase then high phase, each DIV+1 clk. txd/txe update on the
//   clk where MDC goes low; mdio_rxd is sampled on the last clk of the high phase (MDC 1->0).
//   Read data bits 48..63 shift into RDATA MSB first.
//  FSM: IDLE -> SHIFT(bit 0..63) -> IDLE. busy=1 from the clk after the start write through
//   the end of bit 63's high phase; then MDC=0, txe=0, txd=1, done=1, RDATA committed.
//  Idle: MDC held low, no clock pulses.
// STRUCTURE
//  Package mdio_pkg: register offsets, OP encodings, field bit positions, FRAME_BITS=64.
//  One sub-module mdio_phy_shifter: divider counter + 64-bit frame shifter + read capture;
//   top level holds the bus decode and registers.
// TESTING
//  Reset: rst=0 two clk -> mdio_clk=0, txe=0, txd=1; read DIV -> rxd=32'h18, ack/rxe 1 clk later.
//  Write frame: DIV=1; CMD=0xA5A5_0062 (PHY 3, REG 2, wen=11) -> 64 MDC periods of 4 clk;
//   bits 32..47 = 0101_00011_00010_10, data 0xA5A5; txe=1 throughout.
//  Read frame: CMD=0x0000_0421 (PHY 1, REG 1); PHY model drives 0x1234 -> txe=0 from bit 46;
//   STAT afterwards = 0x1234_0002; a second STAT read = 0x1234_0000.
//  Busy: CMD write mid-frame -> acked; frame bits and PHY/REG unchanged; STAT[0]=1 until frame end.
//  Decode: req at BASE+0x10 -> no ack, no rxe; wen=2'b10 write to CMD -> WDATA updated, no frame.
//  Reset mid-frame at bit 20 -> next clk MDC=0, txe=0, busy=0; a new CMD starts a clean preamble.

Source files
------------

// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_pkg
//  Description : Shared constants, field positions, FSM state type and the
//                Clause-22 frame builder for the MDIO management controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdio_pkg;

    localparam int          c_FRAME_BITS     = 64;

    // Register offsets within the 16-byte window
    localparam logic [3:0]  c_OFF_CMD        = 4'h0;
    localparam logic [3:0]  c_OFF_STAT       = 4'h4;
    localparam logic [3:0]  c_OFF_DIV        = 4'h8;

    // Frame field encodings
    localparam logic [1:0]  c_ST             = 2'b01;
    localparam logic [1:0]  c_OP_READ        = 2'b10;
    localparam logic [1:0]  c_OP_WRITE       = 2'b01;
    localparam logic [1:0]  c_TA_WRITE       = 2'b10;

    // CMD register field positions
    localparam int          c_CMD_REGAD_LSB  = 0;
    localparam int          c_CMD_PHYAD_LSB  = 5;
    localparam int          c_CMD_OP_BIT     = 10;
    localparam int          c_CMD_WDATA_LSB  = 16;

    // Bit indices inside the frame
    localparam logic [5:0]  c_READ_TURN_BIT  = 6'd46;   // master releases MDIO from here
    localparam logic [5:0]  c_READ_DATA_BIT  = 6'd48;   // first PHY data bit

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_t;

    // Full 64-bit frame, MSB transmitted first. For reads the TA/data positions
    // hold ones; they are never driven because txe is low there.
    function automatic logic [c_FRAME_BITS-1:0] build_frame(
        input logic        op_read,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        build_frame = {32'hFFFF_FFFF, c_ST,
                       (op_read ? c_OP_READ : c_OP_WRITE),
                       phyad, regad,
                       (op_read ? 2'b11 : c_TA_WRITE),
                       (op_read ? 16'hFFFF : wdata)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_mgmt_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_mgmt_ctrl_if
//  Description : MGMT bus request/response bundle between the system hub
//                (master) and the MDIO controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdio_mgmt_ctrl_if;
    logic        mgmt_req;
    logic [31:0] mgmt_adr;
    logic        mgmt_rwn;
    logic [1:0]  mgmt_wen;
    logic [31:0] mgmt_txd;
    logic        mgmt_ack;
    logic        mgmt_rxe;
    logic [31:0] mgmt_rxd;

    modport master (
        output mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
        input  mgmt_ack, mgmt_rxe, mgmt_rxd
    );

    modport slave (
        input  mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
        output mgmt_ack, mgmt_rxe, mgmt_rxd
    );
endinterface
`default_nettype wire

// File: rtl/mdio_phy_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_phy_shifter
//  Description : MDC divider, 64-bit Clause-22 frame shifter and read-data
//                capture. One start pulse runs exactly one frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_phy_shifter
    import mdio_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,          // synchronous, active-low
    input  wire logic        i_start,
    input  wire logic        i_op_read,
    input  wire logic [4:0]  i_phyad,
    input  wire logic [4:0]  i_regad,
    input  wire logic [15:0] i_wdata,
    input  wire logic [7:0]  i_div,
    input  wire logic        i_mdio_rxd,
    output logic             o_mdc,
    output logic             o_txe,
    output logic             o_txd,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_rdata
);

    localparam logic [5:0] c_LAST_BIT = 6'(c_FRAME_BITS - 1);

    shift_state_t               r_state;
    shift_state_t               w_state_nxt;
    logic [7:0]                 r_cnt;
    logic [7:0]                 r_div_lat;     // divider frozen for the current bit
    logic                       r_mdc;
    logic [5:0]                 r_bit;
    logic [c_FRAME_BITS-1:0]    r_frame;
    logic                       r_txe;
    logic                       r_op_read;
    logic [15:0]                r_cap;
    logic [15:0]                r_rdata;
    logic                       r_done;

    logic                       w_phase_end;
    logic                       w_bit_end;
    logic                       w_last_bit;
    logic [5:0]                 w_next_bit;

    assign w_phase_end = (r_cnt == r_div_lat);
    assign w_bit_end   = w_phase_end && r_mdc;
    assign w_last_bit  = (r_bit == c_LAST_BIT);
    assign w_next_bit  = r_bit + 6'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state: leave idle on start, return after bit 63's high phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)                 w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_bit_end && w_last_bit) w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // Divider, MDC phase, frame shift and read capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_div_lat <= '0;
            r_mdc     <= 1'b0;
            r_bit     <= '0;
            r_frame   <= '1;
            r_txe     <= 1'b0;
            r_op_read <= 1'b0;
            r_cap     <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (i_start) begin
                    r_frame   <= build_frame(i_op_read, i_phyad, i_regad, i_wdata);
                    r_op_read <= i_op_read;
                    r_cnt     <= '0;
                    r_div_lat <= i_div;
                    r_bit     <= '0;
                    r_mdc     <= 1'b0;
                    r_txe     <= 1'b1;
                end
            end else if (!w_phase_end) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= '0;
                if (!r_mdc) begin
                    r_mdc <= 1'b1;
                end else begin
                    // Last clk of the high phase: sample MDIO, then MDC falls
                    r_mdc <= 1'b0;
                    if (r_op_read && (r_bit >= c_READ_DATA_BIT))
                        r_cap <= {r_cap[14:0], i_mdio_rxd};
                    if (w_last_bit) begin
                        r_txe   <= 1'b0;
                        r_frame <= '1;
                        r_done  <= 1'b1;
                        if (r_op_read)
                            r_rdata <= {r_cap[14:0], i_mdio_rxd};
                    end else begin
                        r_bit     <= w_next_bit;
                        r_frame   <= {r_frame[c_FRAME_BITS-2:0], 1'b1};
                        r_txe     <= !(r_op_read && (w_next_bit >= c_READ_TURN_BIT));
                        r_div_lat <= i_div;
                    end
                end
            end
        end
    end

    assign o_mdc   = r_mdc;
    assign o_txe   = r_txe;
    assign o_txd   = r_frame[c_FRAME_BITS-1];
    assign o_busy  = (r_state == ST_SHIFT);
    assign o_done  = r_done;
    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mdio_mgmt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_mgmt_ctrl
//  Description : MGMT-bus slave with CMD/STAT/DIV registers driving a
//                Clause-22 MDIO master toward the RGMII PHY.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_mgmt_ctrl
    import mdio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0300,
    parameter logic [7:0]  DIV_DEFAULT = 8'd24
) (
    input  wire logic          clk,
    input  wire logic          rst,        // synchronous, active-low
    mdio_mgmt_ctrl_if.slave    mgmt,
    output logic               mdio_clk,
    output logic               mdio_txe,
    output logic               mdio_txd,
    input  wire logic          mdio_rxd
);

    logic [10:0] r_cmd;
    logic [15:0] r_wdata;
    logic [7:0]  r_div;
    logic        r_done;
    logic        r_ack;
    logic        r_rxe;
    logic [31:0] r_rxd;

    logic        w_hit;
    logic [3:0]  w_off;
    logic        w_busy;
    logic        w_frame_done;
    logic [15:0] w_rdata_phy;
    logic        w_cmd_wr;
    logic        w_start;
    logic        w_div_wr;
    logic        w_stat_rd;
    logic [15:0] w_start_wdata;
    logic [31:0] w_rdata;
    logic        w_unused_ok;

    assign w_hit     = mgmt.mgmt_req && (mgmt.mgmt_adr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = mgmt.mgmt_adr[3:0];
    // CMD writes are dropped entirely while a frame is running
    assign w_cmd_wr  = w_hit && !mgmt.mgmt_rwn && (w_off == c_OFF_CMD) && !w_busy;
    assign w_start   = w_cmd_wr && mgmt.mgmt_wen[0];
    assign w_div_wr  = w_hit && !mgmt.mgmt_rwn && (w_off == c_OFF_DIV) && mgmt.mgmt_wen[0];
    assign w_stat_rd = w_hit && mgmt.mgmt_rwn && (w_off == c_OFF_STAT);

    // A start write that also carries WDATA must send the new value
    assign w_start_wdata = mgmt.mgmt_wen[1] ? mgmt.mgmt_txd[c_CMD_WDATA_LSB +: 16] : r_wdata;

    assign w_unused_ok = &{1'b0, mgmt.mgmt_txd[15:11]};

    // Read-data mux; unmapped offsets return zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_CMD:  w_rdata = {r_wdata, 5'b0, r_cmd};
            c_OFF_STAT: w_rdata = {w_rdata_phy, 14'b0, r_done, w_busy};
            c_OFF_DIV:  w_rdata = {24'b0, r_div};
            default:    w_rdata = '0;
        endcase
    end

    // Register file, sticky done flag and one-cycle bus response
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmd   <= '0;
            r_wdata <= '0;
            r_div   <= DIV_DEFAULT;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
            r_rxe   <= 1'b0;
            r_rxd   <= '0;
        end else begin
            r_ack <= w_hit;
            r_rxe <= w_hit && mgmt.mgmt_rwn;
            r_rxd <= (w_hit && mgmt.mgmt_rwn) ? w_rdata : 32'h0;
            if (w_cmd_wr && mgmt.mgmt_wen[0])
                r_cmd <= mgmt.mgmt_txd[10:0];
            if (w_cmd_wr && mgmt.mgmt_wen[1])
                r_wdata <= mgmt.mgmt_txd[c_CMD_WDATA_LSB +: 16];
            if (w_div_wr)
                r_div <= mgmt.mgmt_txd[7:0];
            // Completion wins over a coincident STAT read
            if (w_frame_done)
                r_done <= 1'b1;
            else if (w_start || w_stat_rd)
                r_done <= 1'b0;
        end
    end

    mdio_phy_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_op_read  (mgmt.mgmt_txd[c_CMD_OP_BIT]),
        .i_phyad    (mgmt.mgmt_txd[c_CMD_PHYAD_LSB +: 5]),
        .i_regad    (mgmt.mgmt_txd[c_CMD_REGAD_LSB +: 5]),
        .i_wdata    (w_start_wdata),
        .i_div      (r_div),
        .i_mdio_rxd (mdio_rxd),
        .o_mdc      (mdio_clk),
        .o_txe      (mdio_txe),
        .o_txd      (mdio_txd),
        .o_busy     (w_busy),
        .o_done     (w_frame_done),
        .o_rdata    (w_rdata_phy)
    );

    assign mgmt.mgmt_ack = r_ack;
    assign mgmt.mgmt_rxe = r_rxe;
    assign mgmt.mgmt_rxd = r_rxd;

endmodule
`default_nettype wire

// File: tb/tb_mdio_mgmt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_mgmt_ctrl
//  Description : Self-checking bench for mdio_mgmt_ctrl with a register-level
//                reference model and an MDC-edge frame recorder / PHY model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_mgmt_ctrl;

    localparam logic [31:0] c_BASE = 32'h0000_0300;
    localparam logic [3:0]  c_CMD  = 4'h0;
    localparam logic [3:0]  c_STAT = 4'h4;
    localparam logic [3:0]  c_DIV  = 4'h8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mdio_clk, mdio_txe, mdio_txd;
    logic mdio_rxd = 1'b1;

    mdio_mgmt_ctrl_if bus_if ();

    mdio_mgmt_ctrl #(.BASE_ADDR(c_BASE), .DIV_DEFAULT(8'd24)) dut (
        .clk      (clk),
        .rst      (rst),
        .mgmt     (bus_if.slave),
        .mdio_clk (mdio_clk),
        .mdio_txe (mdio_txe),
        .mdio_txd (mdio_txd),
        .mdio_rxd (mdio_rxd)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc       = 0;

    always @(posedge clk) cyc = cyc + 1;

    // ---------------- frame recorder and PHY model ----------------
    int          mon_gen  = 0;
    int          mon_seen = 0;
    int          mon_bits = 0;
    logic [63:0] rec_txd  = '1;
    logic [63:0] rec_txe  = '0;
    int          rise_cyc [64];
    logic        mdc_prev = 1'b0;
    logic [15:0] phy_data = 16'h0;

    // Record txd/txe at each MDC rise; PHY answers read data bits 48..63
    always @(negedge clk) begin
        if (mon_gen != mon_seen) begin
            mon_seen = mon_gen;
            mon_bits = 0;
            rec_txd  = '1;
            rec_txe  = '0;
        end
        if (mdio_clk && !mdc_prev) begin
            if (mon_bits < 64) begin
                rec_txd[63-mon_bits] = mdio_txd;
                rec_txe[63-mon_bits] = mdio_txe;
                rise_cyc[mon_bits]   = cyc;
            end
            if (mon_bits >= 48 && mon_bits < 64) mdio_rxd = phy_data[63-mon_bits];
            else                                 mdio_rxd = 1'b1;
            mon_bits = mon_bits + 1;
        end
        mdc_prev = mdio_clk;
    end

    // ---------------- reference model ----------------
    logic [10:0] m_cmd;
    logic [15:0] m_wdata, m_rdata;
    logic [7:0]  m_div;
    logic        m_done, m_busy;
    logic        ef_rd;
    logic [4:0]  ef_phy, ef_rg;
    logic [15:0] ef_data;
    logic [7:0]  ef_div;

    task automatic model_reset();
        m_cmd = '0; m_wdata = '0; m_rdata = '0; m_div = 8'd24; m_done = 1'b0; m_busy = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] off);
        case (off)
            c_CMD:   return {m_wdata, 5'b0, m_cmd};
            c_STAT:  return {m_rdata, 14'b0, m_done, m_busy};
            c_DIV:   return {24'b0, m_div};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic rwn, input logic [1:0] wen,
                       input logic [31:0] d, output logic ak, output logic re,
                       output logic [31:0] rd);
        @(negedge clk);
        bus_if.mgmt_req = 1'b1; bus_if.mgmt_adr = a; bus_if.mgmt_rwn = rwn;
        bus_if.mgmt_wen = wen;  bus_if.mgmt_txd = d;
        @(posedge clk); #1;
        ak = bus_if.mgmt_ack; re = bus_if.mgmt_rxe; rd = bus_if.mgmt_rxd;
        bus_if.mgmt_req = 1'b0; bus_if.mgmt_wen = 2'b00;
    endtask

    task automatic reg_wr(input string tag, input logic [3:0] off, input logic [1:0] wen,
                          input logic [31:0] d);
        logic ak, re; logic [31:0] rd;
        logic starts;
        starts = (off == c_CMD) && wen[0] && !m_busy;
        if (starts) mon_gen++;
        bus(c_BASE | {28'h0, off}, 1'b0, wen, d, ak, re, rd);
        chk({tag, "/ack"}, {63'h0, ak}, 64'd1);
        chk({tag, "/rxe"}, {63'h0, re}, 64'd0);
        if (off == c_CMD && !m_busy) begin
            if (wen[0]) m_cmd   = d[10:0];
            if (wen[1]) m_wdata = d[31:16];
        end
        if (off == c_DIV && wen[0]) m_div = d[7:0];
        if (starts) begin
            m_busy = 1'b1; m_done = 1'b0;
            ef_rd = d[10]; ef_phy = d[9:5]; ef_rg = d[4:0];
            ef_data = m_wdata; ef_div = m_div;
        end
    endtask

    task automatic reg_rd(input string tag, input logic [3:0] off);
        logic ak, re; logic [31:0] rd, exp;
        exp = model_read(off);
        bus(c_BASE | {28'h0, off}, 1'b1, 2'b00, 32'h0, ak, re, rd);
        chk({tag, "/ack"}, {63'h0, ak}, 64'd1);
        chk({tag, "/rxe"}, {63'h0, re}, 64'd1);
        chk({tag, "/rxd"}, {32'h0, rd}, {32'h0, exp});
        if (off == c_STAT) m_done = 1'b0;
    endtask

    task automatic wait_bits(input int n);
        for (int i = 0; i < 64*2*(ef_div+1) + 100 && mon_bits < n; i++) @(posedge clk);
    endtask

    task automatic finish_frame(input string tag);
        logic [63:0] exp, mask;
        int bad;
        wait_bits(64);
        repeat (2*(ef_div+1) + 4) @(posedge clk);
        #1;
        chk({tag, "/bits"}, mon_bits, 64);
        exp  = {32'hFFFF_FFFF, 2'b01, (ef_rd ? 2'b10 : 2'b01), ef_phy, ef_rg, 2'b10, ef_data};
        mask = ef_rd ? ~64'h3FFFF : '1;
        chk({tag, "/txd"}, rec_txd & mask, exp & mask);
        chk({tag, "/txe"}, rec_txe, mask);
        bad = 0;
        for (int k = 1; k < 64; k++)
            if (rise_cyc[k] - rise_cyc[k-1] != 2*(ef_div+1)) bad++;
        chk({tag, "/period"}, bad, 0);
        chk({tag, "/idle_pins"}, {61'h0, mdio_clk, mdio_txe, mdio_txd}, 64'b001);
        m_busy = 1'b0; m_done = 1'b1;
        if (ef_rd) m_rdata = phy_data;
        reg_rd({tag, "/stat"}, c_STAT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ak, re; logic [31:0] rd, wd;
        logic rdop; logic [4:0] ph, rg; logic [7:0] dv;

        bus_if.mgmt_req = 1'b0; bus_if.mgmt_adr = '0; bus_if.mgmt_rwn = 1'b0;
        bus_if.mgmt_wen = 2'b00; bus_if.mgmt_txd = '0;
        model_reset();

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/pins", {61'h0, mdio_clk, mdio_txe, mdio_txd}, 64'b001);
        chk("rst/ack", {63'h0, bus_if.mgmt_ack}, 64'd0);
        chk("rst/rxd", {32'h0, bus_if.mgmt_rxd}, 64'd0);
        @(negedge clk) rst = 1'b1;
        reg_rd("rst_div", c_DIV);
        @(posedge clk); #1;
        chk("ack_pulse", {62'h0, bus_if.mgmt_ack, bus_if.mgmt_rxe}, 64'd0);
        reg_rd("rst_stat", c_STAT);
        reg_rd("rst_cmd", c_CMD);

        // Directed write frame, DIV=1
        reg_wr("div1", c_DIV, 2'b01, 32'h0000_0001);
        reg_rd("div1_rb", c_DIV);
        reg_wr("wr_cmd", c_CMD, 2'b11, 32'hA5A5_0062);
        finish_frame("wr_frame");
        chk("wr_hdr", {48'h0, rec_txd[31:16]}, 64'h518A);
        chk("wr_data", {48'h0, rec_txd[15:0]}, 64'hA5A5);

        // Directed read frame
        phy_data = 16'h1234;
        reg_wr("rd_cmd", c_CMD, 2'b01, 32'h0000_0421);
        finish_frame("rd_frame");
        reg_rd("stat_again", c_STAT);

        // Busy: CMD write mid-frame is ignored
        reg_wr("busy_cmd", c_CMD, 2'b11, 32'h5A5A_0083);
        wait_bits(10);
        reg_wr("busy_ign", c_CMD, 2'b11, 32'hFFFF_07FF);
        reg_rd("busy_stat", c_STAT);
        reg_rd("busy_cmd_rb", c_CMD);
        finish_frame("busy_frame");

        // Decode
        bus(c_BASE + 32'h10, 1'b1, 2'b00, 32'h0, ak, re, rd);
        chk("miss/resp", {31'h0, ak, re, rd}, 64'h0);
        bus(c_BASE + 32'h10, 1'b0, 2'b11, 32'hFFFF_FFFF, ak, re, rd);
        chk("miss_wr/ack", {63'h0, ak}, 64'd0);
        reg_rd("unmapped", 4'hC);
        reg_wr("ro_wr", c_STAT, 2'b11, 32'hFFFF_FFFF);
        reg_rd("ro_stat", c_STAT);
        mon_gen++;
        reg_wr("wd_only", c_CMD, 2'b10, 32'hBEEF_0421);
        repeat (40) @(posedge clk);
        #1;
        chk("wd_only/no_frame", {32'h0, mon_bits, mdio_clk}, 64'h0);
        reg_rd("wd_only_rb", c_CMD);

        // Random frames; first one at DIV=0
        for (int k = 0; k < 4; k++) begin
            dv   = (k == 0) ? 8'd0 : 8'($urandom_range(0, 3));
            rdop = 1'($urandom_range(0, 1));
            ph   = 5'($urandom);
            rg   = 5'($urandom);
            wd   = $urandom;
            phy_data = 16'($urandom);
            reg_wr("rnd_div", c_DIV, 2'b01, {24'h0, dv});
            reg_wr("rnd_cmd", c_CMD, 2'b11, {wd[15:0], 5'b0, rdop, ph, rg});
            finish_frame("rnd_frame");
        end

        // Reset mid-frame at bit 20
        reg_wr("rm_div", c_DIV, 2'b01, 32'h0000_0001);
        reg_wr("rm_cmd", c_CMD, 2'b11, 32'h1111_0062);
        wait_bits(21);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rm/pins", {62'h0, mdio_clk, mdio_txe}, 64'd0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        reg_rd("rm_stat", c_STAT);
        reg_rd("rm_div_rb", c_DIV);
        reg_wr("rm_new", c_CMD, 2'b11, 32'h0F0F_0145);
        finish_frame("rm_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
